// File: rtl/chip8_video_pkg.sv
// Shared video constants and the 2-bit grey palette for the CHIP-8 VGA back-end.
package chip8_video_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_X_OFF = 64;
    localparam int VGA_Y_OFF = 112;

    // Each CHIP-8 pixel covers a 4x4 block of screen pixels.
    localparam int WIN_W       = 512;
    localparam int WIN_H       = 256;
    localparam int SCALE_SHIFT = 2;

    localparam logic [11:0] VGA_BORDER_RGB = 12'h000;

    function automatic logic [11:0] palette(input logic [1:0] level);
        case (level)
            2'd0:    palette = 12'h000;
            2'd1:    palette = 12'h555;
            2'd2:    palette = 12'hAAA;
            default: palette = 12'hFFF;
        endcase
    endfunction

endpackage

// File: rtl/chip8_vga_timing.sv
// Free-running h/v raster counters with the stage-0 active, sync and frame-tick decode.
module chip8_vga_timing
    import chip8_video_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] h,
    output logic [9:0] v,
    output logic       active,
    output logic       hs,
    output logic       vs,
    output logic       tick
);

    localparam logic [9:0] H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

    // v advances only on the cycle h wraps, so both wraps land on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h <= 10'd0;
            v <= 10'd0;
        end else if (h == H_LAST) begin
            h <= 10'd0;
            v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
        end else begin
            h <= h + 10'd1;
        end
    end

    assign active = (h < H_ACT_END) && (v < V_ACT_END);
    assign hs     = (h >= HS_START) && (h < HS_END);
    assign vs     = (v >= VS_START) && (v < VS_END);
    assign tick   = (h == 10'd0) && (v == V_ACT_END);

endmodule

// File: rtl/chip8_vga_scanout.sv
// CHIP-8 VGA scan-out: maps the raster onto the 4x-scaled VRAM window and
// aligns colour, syncs and frame tick through a two-register pipeline.
module chip8_vga_scanout
    import chip8_video_pkg::*;
#(
    parameter int          H_ACTIVE   = VGA_H_ACTIVE,
    parameter int          H_FP       = VGA_H_FP,
    parameter int          H_SYNC     = VGA_H_SYNC,
    parameter int          H_BP       = VGA_H_BP,
    parameter int          V_ACTIVE   = VGA_V_ACTIVE,
    parameter int          V_FP       = VGA_V_FP,
    parameter int          V_SYNC     = VGA_V_SYNC,
    parameter int          V_BP       = VGA_V_BP,
    parameter int          X_OFF      = VGA_X_OFF,
    parameter int          Y_OFF      = VGA_Y_OFF,
    parameter logic [11:0] BORDER_RGB = VGA_BORDER_RGB
) (
    input  logic        clk,
    input  logic        reset,
    output logic [6:0]  rd_hpos,
    output logic [5:0]  rd_vpos,
    input  logic [1:0]  rd_pixel,
    output logic [11:0] rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        display_on,
    output logic        frame_tick
);

    localparam logic [9:0] X_LO = 10'(X_OFF);
    localparam logic [9:0] X_HI = 10'(X_OFF + WIN_W);
    localparam logic [9:0] Y_LO = 10'(Y_OFF);
    localparam logic [9:0] Y_HI = 10'(Y_OFF + WIN_H);

    logic [9:0] h;
    logic [9:0] v;
    logic       active;
    logic       hs;
    logic       vs;
    logic       tick;
    logic       in_win;

    logic       active_s1;
    logic       in_win_s1;
    logic       hs_s1;
    logic       vs_s1;
    logic       tick_s1;

    chip8_vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk    (clk),
        .reset  (reset),
        .h      (h),
        .v      (v),
        .active (active),
        .hs     (hs),
        .vs     (vs),
        .tick   (tick)
    );

    assign in_win = (h >= X_LO) && (h < X_HI) && (v >= Y_LO) && (v < Y_HI);

    // Address is parked at 0 outside the window so the read port never wanders.
    assign rd_hpos = in_win ? 7'((h - X_LO) >> SCALE_SHIFT) : 7'd0;
    assign rd_vpos = in_win ? 6'((v - Y_LO) >> SCALE_SHIFT) : 6'd0;

    // Stage 1 holds the decode while the VRAM read for the same pixel completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_s1 <= 1'b0;
            in_win_s1 <= 1'b0;
            hs_s1     <= 1'b0;
            vs_s1     <= 1'b0;
            tick_s1   <= 1'b0;
        end else begin
            active_s1 <= active;
            in_win_s1 <= in_win;
            hs_s1     <= hs;
            vs_s1     <= vs;
            tick_s1   <= tick;
        end
    end

    // Stage 2 registers every output so colour and syncs leave on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb        <= 12'h000;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            display_on <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            if (!active_s1) begin
                rgb <= 12'h000;
            end else if (!in_win_s1) begin
                rgb <= BORDER_RGB;
            end else begin
                rgb <= palette(rd_pixel);
            end
            hsync      <= ~hs_s1;
            vsync      <= ~vs_s1;
            display_on <= active_s1;
            frame_tick <= tick_s1;
        end
    end

endmodule

// File: tb/tb_chip8_vga_scanout.sv
// Bench for chip8_vga_scanout: a shrunken-raster instance and a default-timing instance
// share one random VRAM and are compared every cycle against an arithmetic raster model.
module tb_chip8_vga_scanout;

    typedef struct {
        int          hact;
        int          hfp;
        int          hsw;
        int          hbp;
        int          vact;
        int          vfp;
        int          vsw;
        int          vbp;
        int          xoff;
        int          yoff;
        logic [11:0] border;
    } cfg_t;

    localparam int S_FRAME = 544 * 26;

    cfg_t small_cfg   = '{528, 4, 8, 4, 20, 2, 2, 2, 8, 4, 12'h00F};
    cfg_t default_cfg = '{640, 16, 96, 48, 480, 10, 2, 33, 64, 112, 12'h00F};

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [6:0]  s_rd_hpos, d_rd_hpos;
    logic [5:0]  s_rd_vpos, d_rd_vpos;
    logic [1:0]  s_rd_pixel, d_rd_pixel;
    logic [11:0] s_rgb, d_rgb;
    logic        s_hsync, d_hsync, s_vsync, d_vsync;
    logic        s_de, d_de, s_ft, d_ft;

    logic [1:0]  vram [64][128];
    logic [11:0] pal_seq [4] = '{12'h000, 12'h555, 12'hAAA, 12'hFFF};

    int edges = 0;
    int tests = 0;
    int failures = 0;

    always #20 clk = ~clk;

    // Synchronous one-cycle-latency read port shared by both instances.
    always @(posedge clk) begin
        s_rd_pixel <= vram[s_rd_vpos][s_rd_hpos];
        d_rd_pixel <= vram[d_rd_vpos][d_rd_hpos];
    end

    chip8_vga_scanout #(
        .H_ACTIVE (528), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_ACTIVE (20),  .V_FP (2), .V_SYNC (2), .V_BP (2),
        .X_OFF (8), .Y_OFF (4), .BORDER_RGB (12'h00F)
    ) dut_small (
        .clk        (clk),
        .reset      (reset),
        .rd_hpos    (s_rd_hpos),
        .rd_vpos    (s_rd_vpos),
        .rd_pixel   (s_rd_pixel),
        .rgb        (s_rgb),
        .hsync      (s_hsync),
        .vsync      (s_vsync),
        .display_on (s_de),
        .frame_tick (s_ft)
    );

    chip8_vga_scanout #(
        .BORDER_RGB (12'h00F)
    ) dut_default (
        .clk        (clk),
        .reset      (reset),
        .rd_hpos    (d_rd_hpos),
        .rd_vpos    (d_rd_vpos),
        .rd_pixel   (d_rd_pixel),
        .rgb        (d_rgb),
        .hsync      (d_hsync),
        .vsync      (d_vsync),
        .display_on (d_de),
        .frame_tick (d_ft)
    );

    function automatic logic [11:0] pal(input logic [1:0] p);
        case (p)
            2'd0:    return 12'h000;
            2'd1:    return 12'h555;
            2'd2:    return 12'hAAA;
            default: return 12'hFFF;
        endcase
    endfunction

    function automatic void raster(input cfg_t c, input int idx, output int h, output int v);
        int htot = c.hact + c.hfp + c.hsw + c.hbp;
        int vtot = c.vact + c.vfp + c.vsw + c.vbp;
        h = idx % htot;
        v = (idx / htot) % vtot;
    endfunction

    function automatic bit in_window(input cfg_t c, input int h, input int v);
        return (h >= c.xoff) && (h < c.xoff + 512) && (v >= c.yoff) && (v < c.yoff + 256);
    endfunction

    // idx is the raster position (cycles since release) whose result is on the outputs.
    function automatic void model_out(input cfg_t c, input int idx, output logic [11:0] rgb,
                                      output logic hs, output logic vs, output logic de,
                                      output logic ft);
        int h, v;
        if (idx < 0) begin
            rgb = 12'h000; hs = 1'b1; vs = 1'b1; de = 1'b0; ft = 1'b0;
            return;
        end
        raster(c, idx, h, v);
        de = (h < c.hact) && (v < c.vact);
        hs = !((h >= c.hact + c.hfp) && (h < c.hact + c.hfp + c.hsw));
        vs = !((v >= c.vact + c.vfp) && (v < c.vact + c.vfp + c.vsw));
        ft = (h == 0) && (v == c.vact);
        if (!de)
            rgb = 12'h000;
        else if (!in_window(c, h, v))
            rgb = c.border;
        else
            rgb = pal(vram[(v - c.yoff) / 4][(h - c.xoff) / 4]);
    endfunction

    function automatic void model_addr(input cfg_t c, input int idx, output logic [6:0] ha,
                                       output logic [5:0] va);
        int h, v;
        raster(c, idx, h, v);
        ha = in_window(c, h, v) ? 7'((h - c.xoff) / 4) : 7'd0;
        va = in_window(c, h, v) ? 6'((v - c.yoff) / 4) : 6'd0;
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s at edge %0d: observed %h, expected %h", tag, edges, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs == exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus();
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 128; c++)
                vram[r][c] = 2'($urandom_range(0, 3));
        vram[0][0]   = 2'd0;
        vram[0][1]   = 2'd1;
        vram[0][2]   = 2'd2;
        vram[0][3]   = 2'd3;
        vram[0][127] = 2'd3;
    endtask

    task automatic check_output();
        logic [11:0] e_rgb;
        logic        e_hs, e_vs, e_de, e_ft;
        logic [6:0]  e_ha;
        logic [5:0]  e_va;
        int          h, v;

        model_out(small_cfg, edges - 2, e_rgb, e_hs, e_vs, e_de, e_ft);
        chk("s_rgb", s_rgb, e_rgb);
        chk("s_hsync", 12'(s_hsync), 12'(e_hs));
        chk("s_vsync", 12'(s_vsync), 12'(e_vs));
        chk("s_display_on", 12'(s_de), 12'(e_de));
        chk("s_frame_tick", 12'(s_ft), 12'(e_ft));
        model_addr(small_cfg, edges, e_ha, e_va);
        chk("s_rd_hpos", 12'(s_rd_hpos), 12'(e_ha));
        chk("s_rd_vpos", 12'(s_rd_vpos), 12'(e_va));

        model_out(default_cfg, edges - 2, e_rgb, e_hs, e_vs, e_de, e_ft);
        chk("d_rgb", d_rgb, e_rgb);
        chk("d_hsync", 12'(d_hsync), 12'(e_hs));
        chk("d_vsync", 12'(d_vsync), 12'(e_vs));
        chk("d_display_on", 12'(d_de), 12'(e_de));
        chk("d_frame_tick", 12'(d_ft), 12'(e_ft));
        model_addr(default_cfg, edges, e_ha, e_va);
        chk("d_rd_hpos", 12'(d_rd_hpos), 12'(e_ha));
        chk("d_rd_vpos", 12'(d_rd_vpos), 12'(e_va));

        // Hand-derived spot values for the known row-0 pattern, border and blanking.
        if (edges >= 2) begin
            raster(small_cfg, edges - 2, h, v);
            if (v == 4 && h >= 8 && h < 24) chk("palette_row0", s_rgb, pal_seq[(h - 8) / 4]);
            if (v == 4 && h >= 516 && h < 520) chk("last_column", s_rgb, 12'hFFF);
            if (v == 22 && h == 10) begin
                chk("vblank_rgb", s_rgb, 12'h000);
                chk("vblank_de", 12'(s_de), 12'h000);
            end
            raster(default_cfg, edges - 2, h, v);
            if (v == 10 && h == 10) begin
                chk("border_rgb", d_rgb, 12'h00F);
                chk("border_de", 12'(d_de), 12'h001);
            end
            if (v == 10 && h == 700) begin
                chk("hblank_rgb", d_rgb, 12'h000);
                chk("hblank_de", 12'(d_de), 12'h000);
            end
        end
        raster(small_cfg, edges, h, v);
        if (v == 4 && h == 8)  chk("rd_hpos_first", 12'(s_rd_hpos), 12'h000);
        if (v == 4 && h == 12) chk("rd_hpos_second", 12'(s_rd_hpos), 12'h001);
    endtask

    task automatic check_reset_values();
        chk("rst_s_rgb", s_rgb, 12'h000);
        chk("rst_s_hsync", 12'(s_hsync), 12'h001);
        chk("rst_s_vsync", 12'(s_vsync), 12'h001);
        chk("rst_s_de", 12'(s_de), 12'h000);
        chk("rst_s_ft", 12'(s_ft), 12'h000);
        chk("rst_s_rd_hpos", 12'(s_rd_hpos), 12'h000);
        chk("rst_s_rd_vpos", 12'(s_rd_vpos), 12'h000);
        chk("rst_d_rgb", d_rgb, 12'h000);
        chk("rst_d_hsync", 12'(d_hsync), 12'h001);
        chk("rst_d_vsync", 12'(d_vsync), 12'h001);
        chk("rst_d_de", 12'(d_de), 12'h000);
        chk("rst_d_ft", 12'(d_ft), 12'h000);
    endtask

    task automatic step();
        @(posedge clk);
        edges++;
        @(negedge clk);
        check_output();
    endtask

    initial begin
        int de_cnt = 0;
        int hs_low = 0;
        int vs_low = 0;
        int s_first = -1;
        int d_first = -1;
        int ticks[$];

        apply_stimulus();
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_output();
        end
        reset = 1'b0;
        edges = 0;

        // Two full frames of the shrunken raster.
        repeat (2 * S_FRAME + 10) begin
            step();
            if (edges >= 2 && edges < 2 + 2 * S_FRAME) begin
                de_cnt += int'(s_de);
                hs_low += int'(!s_hsync);
                vs_low += int'(!s_vsync);
                if (s_ft) ticks.push_back(edges);
            end
        end
        chk_int("display_on_count", de_cnt, 2 * 528 * 20);
        chk_int("hsync_low_count", hs_low, 2 * 26 * 8);
        chk_int("vsync_low_count", vs_low, 2 * 2 * 544);
        chk_int("frame_tick_count", ticks.size(), 2);
        if (ticks.size() == 2) begin
            chk_int("frame_tick_first", ticks[0], 20 * 544 + 2);
            chk_int("frame_tick_period", ticks[1] - ticks[0], S_FRAME);
        end

        // Run on to h=300, v=10 of the third frame, then reset asynchronously.
        while (edges < 2 * S_FRAME + 10 * 544 + 300) step();
        reset = 1'b1;
        #1;
        check_reset_values();
        edges = 0;
        apply_stimulus();
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_output();
        end
        reset = 1'b0;

        repeat (700) begin
            step();
            if (s_first < 0 && !s_hsync) s_first = edges;
            if (d_first < 0 && !d_hsync) d_first = edges;
        end
        chk_int("s_hsync_first_fall", s_first, 532 + 2);
        chk_int("d_hsync_first_fall", d_first, 656 + 2);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
